sdm_cic_decimator: RTL and testbench



---
 rtl/sdm_dec_pkg.sv | 25 ++
 rtl/sdm_cic_integ.sv | 28 ++
 rtl/sdm_cic_decimator.sv | 138 +++++++++++++
 tb/tb_sdm_cic_decimator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sdm_dec_pkg.sv
// Shared types and sizing for the SDM CIC decimator.
// ACC_W is derived from the input width, order and decimation ratio.
package sdm_dec_pkg;

   localparam int R_LOG2 = 7;
   localparam int ORDER  = 4;
   localparam int IN_W   = 5;
   localparam int OUT_W  = 24;

   function automatic int acc_width(input int in_w,
                                    input int order,
                                    input int r_log2);
      return in_w + order * r_log2;
   endfunction

   localparam int ACC_W = acc_width(IN_W, ORDER, R_LOG2);
   localparam int STG_W = (ORDER > 1) ? $clog2(ORDER) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COMB,
      OUT
   } dec_state_e;

endpackage

// File: rtl/sdm_cic_integ.sv
// One wrapping ACC_W-bit integrator stage of the CIC decimator.
// Overflow wraps by design; the comb section cancels it.
module sdm_cic_integ
   import sdm_dec_pkg::*;
(
   input  logic             clock,
   input  logic             rstn,
   input  logic             en_i,
   input  logic [ACC_W-1:0] x_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (en_i) acc_d = acc_q + x_i;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/sdm_cic_decimator.sv
// 4th-order CIC decimator (R=128) for the 5-bit SDM code stream.
// Define SDM_DEC_ROUND_EN for round-half-up instead of truncation.
module sdm_cic_decimator
   import sdm_dec_pkg::*;
(
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    en,
   input  logic [IN_W-1:0]         DataIn,
   output logic [OUT_W-1:0]        DataOut,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);

   logic [ACC_W-1:0] integ [ORDER+1];

   assign integ[0] = {{(ACC_W-IN_W){DataIn[IN_W-1]}}, DataIn};

   for (genvar k = 0; k < ORDER; k++) begin : g_int
      sdm_cic_integ u_int (
         .clock (clock),
         .rstn  (rstn),
         .en_i  (en),
         .x_i   (integ[k]),
         .acc_o (integ[k+1])
      );
   end

   logic [R_LOG2-1:0] cnt_q, cnt_d;
   logic              frame_q, frame_d;
   dec_state_e        state_q, state_d;
   logic [STG_W-1:0]  stg_q, stg_d;

   always_comb begin
      cnt_d   = cnt_q;
      frame_d = frame_q;
      if (state_q == IDLE && frame_q) frame_d = 1'b0;
      if (en) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) frame_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      stg_d   = stg_q;
      unique case (state_q)
         IDLE: begin
            if (frame_q) begin
               state_d = COMB;
               stg_d   = '0;
            end
         end
         COMB: begin
            stg_d = stg_q + 1'b1;
            if (stg_q == STG_W'(ORDER-1)) state_d = OUT;
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         cnt_q   <= '0;
         frame_q <= 1'b0;
         state_q <= IDLE;
         stg_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         state_q <= state_d;
         stg_q   <= stg_d;
      end
   end

   // One shared subtractor walks the comb delays, one stage per cycle.
   logic [ACC_W-1:0] work_q;
   logic [ACC_W-1:0] dly_q [ORDER];

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         work_q <= '0;
         for (int i = 0; i < ORDER; i++) dly_q[i] <= '0;
      end else if (state_q == IDLE && frame_q) begin
         work_q <= integ[ORDER];
      end else if (state_q == COMB) begin
         work_q        <= work_q - dly_q[stg_q];
         dly_q[stg_q]  <= work_q;
      end
   end

   logic [ACC_W-1:0] rnd;
`ifdef SDM_DEC_ROUND_EN
   localparam logic [ACC_W-1:0] RND_HALF = ACC_W'(1) << (ACC_W-OUT_W-1);
   assign rnd = work_q + RND_HALF;
`else
   assign rnd = work_q;
`endif

   logic unused_lsb;
   assign unused_lsb = ^rnd[ACC_W-OUT_W-1:0];

   logic [OUT_W-1:0] dout_q, dout_d;
   logic             vld_q, vld_d;
   logic             ovr_q, ovr_d;

   always_comb begin
      dout_d = dout_q;
      vld_d  = vld_q;
      ovr_d  = ovr_q;
      if (state_q == OUT) begin
         dout_d = rnd[ACC_W-1 -: OUT_W];
         vld_d  = 1'b1;
         if (vld_q && !out_ready) ovr_d = 1'b1;
      end else if (vld_q && out_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         vld_q  <= vld_d;
         ovr_q  <= ovr_d;
      end
   end

   assign DataOut   = dout_q;
   assign out_valid = vld_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Scoreboard bench for sdm_cic_decimator: directed DC/alternating
// patterns, handshake overrun, en stall and mid-frame reset.
module tb_sdm_cic_decimator;

   logic        clock;
   logic        rstn;
   logic        en;
   logic [4:0]  DataIn;
   logic [23:0] DataOut;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;

   sdm_cic_decimator dut (
      .clock     (clock),
      .rstn      (rstn),
      .en        (en),
      .DataIn    (DataIn),
      .DataOut   (DataOut),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   typedef struct {
      bit          chk;
      logic [23:0] val;
   } exp_t;

   localparam int ALT = 99;

   exp_t sb[$];
   int   t_out[$];
   int   cyc;
   int   nsamp;
   int   n_cmp;
   int   n_bad;
   int   c0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   // Monitor: every accepted sample is popped from the scoreboard.
   always @(negedge clock) begin
      exp_t e;
      if (out_valid && out_ready) begin
         t_out.push_back(cyc);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got sample 0x%0h expected none", DataOut);
         end else begin
            e = sb.pop_front();
            if (e.chk) check("sample", longint'(DataOut), longint'(e.val));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) step();
   endtask

   function automatic logic [4:0] code_of(input int mode);
      if (mode == ALT) return nsamp[0] ? 5'h1f : 5'h01;
      return 5'(mode);
   endfunction

   task automatic push_frames(input int n, input logic [23:0] v);
      for (int f = 1; f <= n; f++) sb.push_back('{chk: (f > 4), val: v});
   endtask

   task automatic drive_frames(input int n, input int mode, input int gap);
      for (int f = 1; f <= n; f++) begin
         for (int i = 0; i < 128; i++) begin
            if (f == gap && i == 60) begin
               en = 1'b0;
               repeat (50) step();
            end
            en     = 1'b1;
            DataIn = code_of(mode);
            nsamp++;
            step();
         end
      end
      en = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      nsamp = 0;
      t_out.delete();
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      nsamp     = 0;
      rstn      = 1'b0;
      en        = 1'b0;
      DataIn    = '0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_dout", longint'(DataOut), 0);
      check("rst_valid", longint'(out_valid), 0);
      check("rst_ovr", longint'(overrun), 0);
      rstn = 1'b1;
      t_out.delete();

      // DC +4 with a 50-cycle en stall inside frame 7.
      push_frames(8, 24'h200000);
      drive_frames(8, 4, 7);
      idle(10);
      check("dc4_count", t_out.size(), 8);
      if (t_out.size() >= 8)
         for (int i = 1; i < 8; i++)
            check($sformatf("dc4_gap%0d", i), t_out[i] - t_out[i-1],
                  (i == 6) ? 178 : 128);
      check("dc4_ovr", longint'(overrun), 0);
      check("dc4_sb_empty", sb.size(), 0);

      do_reset();
      push_frames(6, 24'h800000);
      drive_frames(6, -16, 0);
      idle(10);
      check("neg16_sb_empty", sb.size(), 0);

      do_reset();
      push_frames(6, 24'h780000);
      drive_frames(6, 15, 0);
      idle(10);
      check("pos15_sb_empty", sb.size(), 0);

      do_reset();
      push_frames(6, 24'h000000);
      drive_frames(6, ALT, 0);
      idle(10);
      check("alt_sb_empty", sb.size(), 0);

      // Two outputs with no consumer: second overwrites, overrun sticks.
      do_reset();
      push_frames(4, 24'h200000);
      drive_frames(4, 4, 0);
      idle(8);
      out_ready = 1'b0;
      sb.push_back('{chk: 1'b1, val: 24'h200000});
      drive_frames(2, 4, 0);
      idle(8);
      check("ovr_valid_held", longint'(out_valid), 1);
      check("ovr_set", longint'(overrun), 1);
      out_ready = 1'b1;
      step();
      check("ovr_valid_clr", longint'(out_valid), 0);
      check("ovr_sticky", longint'(overrun), 1);
      check("ovr_sb_empty", sb.size(), 0);

      // Asynchronous reset at cnt=60, then first-output latency.
      for (int i = 0; i < 60; i++) begin
         en     = 1'b1;
         DataIn = 5'd4;
         step();
      end
      rstn = 1'b0;
      #1;
      check("arst_dout", longint'(DataOut), 0);
      check("arst_valid", longint'(out_valid), 0);
      check("arst_ovr", longint'(overrun), 0);
      repeat (3) step();
      rstn = 1'b1;
      t_out.delete();
      nsamp = 0;
      c0 = cyc;
      push_frames(2, 24'h200000);
      drive_frames(2, 4, 0);
      idle(8);
      check("arst_latency", (t_out.size() > 0) ? t_out[0] - c0 : -1, 134);
      check("arst_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
